// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS boot path.
// Holds the loader state encoding and stream framing constants.
package mips_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LEN_HI  = 3'd1;
  localparam logic [2:0] S_LEN_LO  = 3'd2;
  localparam logic [2:0] S_COLLECT = 3'd3;
  localparam logic [2:0] S_WRITE   = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_ERR     = 3'd6;

  typedef enum logic [2:0] {
    IDLE    = S_IDLE,
    LEN_HI  = S_LEN_HI,
    LEN_LO  = S_LEN_LO,
    COLLECT = S_COLLECT,
    WRITE   = S_WRITE,
    DONE    = S_DONE,
    ERR     = S_ERR
  } ld_state_e;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/word_assembler.sv
// Packs a byte stream into big-endian 32-bit words.
// Ports: clk, rst, clear, shift_en, byte_in -> word_out, word_full.
module word_assembler
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        word_full
);

  localparam logic [1:0] LAST = 2'(BYTES_PER_WORD - 1);

  logic [31:0] sr_q;
  logic [31:0] sr_d;
  logic [1:0]  cnt_q;

  // word_out shows the word including the byte shifted in this
  // cycle, so the loader can latch a full word on the 4th byte.
  always_comb begin
    sr_d = sr_q;
    if (shift_en) sr_d = {sr_q[23:0], byte_in};
  end

  assign word_out  = sr_d;
  assign word_full = shift_en && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (shift_en) begin
      sr_q  <= sr_d;
      cnt_q <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Boot loader: byte stream -> instruction memory word writes.
// Ports: start/in_* stream in; wr_* memory port; cpu_rst/done/error status.
module inst_mem_loader
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);

  localparam logic [31:0] DEPTH_U = DEPTH_WORDS;

  ld_state_e   state_q;
  logic [7:0]  n_hi_q;
  logic [15:0] n_q;
  logic [15:0] word_cnt_q;
  logic [15:0] n_d;
  logic [17:0] byte_addr;
  logic        xfer;
  logic        start_ok;
  logic        shift_en;
  logic [31:0] asm_word;
  logic        asm_full;

  assign xfer      = in_valid && in_ready;
  assign start_ok  = start && (state_q == IDLE ||
                               state_q == DONE ||
                               state_q == ERR);
  assign shift_en  = xfer && (state_q == COLLECT);
  assign n_d       = {n_hi_q, in_data};
  assign byte_addr = {word_cnt_q, 2'b00};

  word_assembler u_asm (
    .clk      (clk),
    .rst      (rst),
    .clear    (start_ok),
    .shift_en (shift_en),
    .byte_in  (in_data),
    .word_out (asm_word),
    .word_full(asm_full)
  );

  // Outputs are registered alongside the state so they always
  // reflect the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      n_hi_q     <= '0;
      n_q        <= '0;
      word_cnt_q <= '0;
      in_ready   <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      cpu_rst    <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      unique case (state_q)
        IDLE, DONE, ERR: begin
          if (start) begin
            state_q    <= LEN_HI;
            word_cnt_q <= '0;
            wr_addr    <= '0;
            in_ready   <= 1'b1;
            cpu_rst    <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
          end
        end
        LEN_HI: begin
          if (xfer) begin
            n_hi_q  <= in_data;
            state_q <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (xfer) begin
            n_q <= n_d;
            if (n_d == 16'd0) begin
              state_q  <= DONE;
              in_ready <= 1'b0;
              done     <= 1'b1;
              cpu_rst  <= 1'b0;
            end else if ({16'd0, n_d} > DEPTH_U) begin
              state_q  <= ERR;
              in_ready <= 1'b0;
              error    <= 1'b1;
            end else begin
              state_q <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (asm_full) begin
            state_q  <= WRITE;
            in_ready <= 1'b0;
            wr_en    <= 1'b1;
            wr_data  <= asm_word;
            wr_addr  <= ADDR_W'(byte_addr);
          end
        end
        WRITE: begin
          word_cnt_q <= word_cnt_q + 16'd1;
          if (word_cnt_q + 16'd1 == n_q) begin
            state_q <= DONE;
            done    <= 1'b1;
            cpu_rst <= 1'b0;
          end else begin
            state_q  <= COLLECT;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          in_ready <= 1'b0;
          cpu_rst  <= 1'b1;
        end
      endcase
    end
  end

endmodule
